syscall_print_seq: RTL and testbench

Multi-cycle sequencer for the SYSCALL instruction in the pipelined MIPS core. When the decoder flags a syscall, this block freezes the pipeline, reads `$v0`/`$a0` and performs the service: it walks data memory byte by byte for print_string, emits a single byte for print_char, or halts the core for exit. It arbitrates the data-memory read port away from the MEM stage while it is busy, and drives a ready/valid character stream toward the console model.

---
 rtl/mips_sys_pkg.sv | 16 +
 rtl/sys_byte_sel.sv | 17 +
 rtl/syscall_print_seq.sv | 127 ++++++++++++
 tb/tb_syscall_print_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_sys_pkg.sv
// Shared SYSCALL sequencer definitions: service codes and state type.
package mips_sys_pkg;

  localparam logic [31:0] SYS_PRINT_STR = 32'd4;
  localparam logic [31:0] SYS_EXIT      = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHR = 32'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_DONE,
    S_HALT
  } sys_state_t;

endpackage

// File: rtl/sys_byte_sel.sv
// Big-endian byte lane select: lane 0 is the most significant byte.
module sys_byte_sel (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  output logic [7:0]  data
);

  always_comb begin
    unique case (lane)
      2'd0:    data = word[31:24];
      2'd1:    data = word[23:16];
      2'd2:    data = word[15:8];
      default: data = word[7:0];
    endcase
  end

endmodule

// File: rtl/syscall_print_seq.sv
// SYSCALL sequencer: print_string / print_char / exit services with
// pipeline stall, data-memory port steal and ready/valid char stream.
module syscall_print_seq
  import mips_sys_pkg::*;
#(
  parameter int MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall_valid,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        done,
  output logic        err,
  output logic        halted
);

  localparam int CW = $clog2(MAX_LEN + 1);

  sys_state_t    state;
  sys_state_t    state_nxt;
  logic [31:0]   ptr;
  logic [31:0]   wbuf;
  logic [CW-1:0] count;
  logic          is_str;
  logic          err_q;
  logic [7:0]    cur_byte;
  logic          is_nul;
  logic          xfer;
  logic          at_max;
  logic [31:0]   ptr_inc;
  logic          code_str;
  logic          code_chr;
  logic          code_exit;

  sys_byte_sel u_sel (
    .word (wbuf),
    .lane (ptr[1:0]),
    .data (cur_byte)
  );

  assign code_str  = (v0 == SYS_PRINT_STR);
  assign code_chr  = (v0 == SYS_PRINT_CHR);
  assign code_exit = (v0 == SYS_EXIT);
  assign is_nul    = is_str && (cur_byte == 8'h00);
  assign xfer      = (state == S_EMIT) && !is_nul && char_ready;
  assign at_max    = (count == CW'(MAX_LEN - 1));
  assign ptr_inc   = ptr + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (syscall_valid) begin
          unique case (1'b1)
            code_str:  state_nxt = S_FETCH;
            code_chr:  state_nxt = S_EMIT;
            code_exit: state_nxt = S_HALT;
            default:   state_nxt = S_DONE;
          endcase
        end
      end
      S_FETCH: if (mem_ack) state_nxt = S_EMIT;
      S_EMIT: begin
        if (is_nul) begin
          state_nxt = S_DONE;
        end else if (xfer) begin
          if (!is_str || at_max)       state_nxt = S_DONE;
          else if (ptr_inc[1:0] == '0) state_nxt = S_FETCH;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // print_char rides the string datapath: byte parked in lane 3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      wbuf   <= '0;
      count  <= '0;
      is_str <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && syscall_valid) begin
        err_q  <= !(code_str || code_chr || code_exit);
        is_str <= code_str;
        count  <= '0;
        ptr    <= code_str ? a0 : 32'd3;
        wbuf   <= {24'd0, a0[7:0]};
      end
      if (state == S_FETCH && mem_ack) wbuf <= mem_rdata;
      if (xfer) begin
        ptr   <= ptr_inc;
        count <= count + 1'b1;
        if (is_str && at_max) err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    stall      = (state != S_IDLE) || syscall_valid;
    mem_req    = (state == S_FETCH);
    mem_addr   = mem_req ? {ptr[31:2], 2'b00} : '0;
    char_valid = (state == S_EMIT) && !is_nul;
    char_data  = char_valid ? cur_byte : '0;
    done       = (state == S_DONE);
    halted     = (state == S_HALT);
    err        = err_q;
  end

endmodule

// File: tb/tb_syscall_print_seq.sv
// Randomized scoreboard bench for syscall_print_seq with memory/console models.
module tb_syscall_print_seq;

  localparam int MAX = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        syscall_valid = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready = 1'b0;
  logic        done;
  logic        err;
  logic        halted;

  syscall_print_seq #(.MAX_LEN(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .syscall_valid(syscall_valid),
    .v0(v0), .a0(a0), .stall(stall), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .done(done), .err(err), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  bit hold_low = 1'b0;

  logic [31:0] mem [bit [31:0]];
  logic [7:0]  exp_chars [$];
  logic [31:0] exp_fetch [$];
  logic        exp_err [$];

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [31:0] rd_word(bit [31:0] a);
    bit [31:0] w = a & 32'hFFFF_FFFC;
    return mem.exists(w) ? mem[w] : 32'd0;
  endfunction

  function automatic logic [7:0] rd_byte(bit [31:0] a);
    int sh = 8 * (3 - int'(a % 4));
    return 8'((rd_word(a) >> sh) & 32'hFF);
  endfunction

  task automatic set_byte(bit [31:0] a, logic [7:0] b);
    bit [31:0]   w = a & 32'hFFFF_FFFC;
    int          sh = 8 * (3 - int'(a % 4));
    logic [31:0] d = rd_word(a);
    d = (d & ~(32'hFF << sh)) | ({24'd0, b} << sh);
    mem[w] = d;
  endtask

  // Reference model: the service outcome from the rules, not the FSM
  task automatic push_expect(logic [31:0] code, logic [31:0] arg);
    bit [31:0] p;
    int        n;
    logic [7:0] b;
    logic       e;
    if (code == 32'd4) begin
      p = arg;
      n = 0;
      e = 1'b0;
      exp_fetch.push_back(p & 32'hFFFF_FFFC);
      while (1) begin
        b = rd_byte(p);
        if (b == 8'h00) break;
        exp_chars.push_back(b);
        n++;
        if (n == MAX) begin
          e = 1'b1;
          break;
        end
        p = p + 1;
        if (p % 4 == 0) exp_fetch.push_back(p);
      end
      exp_err.push_back(e);
    end else if (code == 32'd11) begin
      exp_chars.push_back(arg[7:0]);
      exp_err.push_back(1'b0);
    end else if (code != 32'd10) begin
      exp_err.push_back(1'b1);
    end
  endtask

  // Environment + monitor: drive ready/ack, then score what happens next edge
  always @(negedge clk) begin : env
    logic [7:0]  ec;
    logic [31:0] ea;
    char_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (rst_n && mem_req && $urandom_range(0, 2) == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = rd_word(mem_addr);
      if (exp_fetch.size() == 0) begin
        check("unexpected_fetch", mem_addr, 32'hFFFF_FFFF);
      end else begin
        ea = exp_fetch.pop_front();
        check("fetch_addr", mem_addr, ea);
      end
    end
    if (rst_n && char_valid && char_ready) begin
      if (exp_chars.size() == 0) begin
        check("unexpected_char", {24'd0, char_data}, 32'h100);
      end else begin
        ec = exp_chars.pop_front();
        check("char", {24'd0, char_data}, {24'd0, ec});
      end
    end
    if (rst_n && done) begin
      done_cnt++;
      check("stall_at_done", {31'd0, stall}, 32'd1);
      if (exp_err.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        ea = {31'd0, exp_err.pop_front()};
        check("err", {31'd0, err}, ea);
      end
    end
  end

  task automatic issue(logic [31:0] code, logic [31:0] arg);
    @(negedge clk);
    syscall_valid = 1'b1;
    v0 = code;
    a0 = arg;
    #1 check("stall_decode", {31'd0, stall}, 32'd1);
    @(negedge clk);
    syscall_valid = 1'b0;
  endtask

  task automatic wait_done(int target);
    int k;
    for (k = 0; k < 8000; k++) begin
      if (done_cnt >= target) break;
      @(negedge clk);
    end
    if (done_cnt < target) fail_now("done_timeout");
    check("chars_left", exp_chars.size(), 0);
    check("fetch_left", exp_fetch.size(), 0);
  endtask

  task automatic run_sys(logic [31:0] code, logic [31:0] arg);
    int target = done_cnt + 1;
    push_expect(code, arg);
    issue(code, arg);
    wait_done(target);
  endtask

  task automatic wait_cv();
    int k;
    for (k = 0; k < 20; k++) begin
      if (char_valid) break;
      @(negedge clk);
    end
    if (!char_valid) fail_now("char_valid_timeout");
  endtask

  initial begin
    int target;
    int len;
    bit [31:0] base;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_outs", {mem_req, char_valid, done, err, halted}, 0);
    check("rst_addr_data", mem_addr ^ {24'd0, char_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mem[32'h100] = 32'h4869_0000;
    run_sys(4, 32'h100);
    mem[32'h100] = 32'h0000_0041;
    mem[32'h104] = 32'h4200_0000;
    run_sys(4, 32'h103);

    for (int i = 0; i < 4; i++) set_byte(32'hFFFF_FFFE + i, 8'h61 + 8'(i));
    set_byte(32'h2, 8'h00);
    run_sys(4, 32'hFFFF_FFFE);

    for (int i = 0; i < 1030; i++)
      set_byte(32'h4000 + i, 8'($urandom_range(1, 255)));
    set_byte(32'h4000 + 1030, 8'h00);
    run_sys(4, 32'h4000);

    target = done_cnt + 1;
    hold_low = 1'b1;
    push_expect(11, 32'h7A);
    issue(11, 32'h7A);
    wait_cv();
    for (int i = 0; i < 5; i++) begin
      check("hold_char", {23'd0, char_valid, char_data}, 32'h17A);
      if (i < 4) @(negedge clk);
    end
    hold_low = 1'b0;
    wait_done(target);

    for (int i = 0; i < 25; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 6) begin
        base = 32'h2000 + $urandom_range(0, 255);
        len = $urandom_range(0, 10);
        for (int j = 0; j < len; j++)
          set_byte(base + j, 8'($urandom_range(1, 255)));
        set_byte(base + len, 8'h00);
        run_sys(4, base);
      end else if (r < 9) begin
        run_sys(11, $urandom);
      end else begin
        run_sys($urandom_range(12, 200), $urandom);
      end
    end

    target = done_cnt;
    issue(10, 0);
    repeat (3) @(negedge clk);
    check("halted", {31'd0, halted}, 1);
    check("halt_stall", {31'd0, stall}, 1);
    issue(11, 32'h55);
    repeat (10) @(negedge clk);
    check("halt_ignores", {31'd0, halted, stall}, 3);
    check("halt_no_done", done_cnt, target);
    rst_n = 1'b0;
    #1 check("halt_rst", {30'd0, halted, stall}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sys(99, 0);

    hold_low = 1'b1;
    issue(11, 32'h55);
    wait_cv();
    rst_n = 1'b0;
    #1 check("rst_emit_char", {23'd0, char_valid, char_data}, 0);
    check("rst_emit_ctl", {stall, mem_req, done, err, halted}, 0);
    check("rst_emit_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_low = 1'b0;
    run_sys(11, 32'h33);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
